// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock, valid/ready on both sides.
// Optional BOOTH_SEQ_SKIP_EN: finish early once the remaining multiplier digits are all zero.
module booth_r4_seq_mult #(
  parameter int WIDTH = 18
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_multa_ns,
  input  logic               i_multb_ns,
  input  logic [WIDTH-1:0]   i_multa,
  input  logic [WIDTH-1:0]   i_multb,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int N     = WIDTH / 2 + 1;
  localparam int YW    = WIDTH + 3;
  localparam int ACC_W = 2 * WIDTH + 2;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   x_sh_q, x_sh_d;
  logic [YW-1:0]      y_q, y_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [ACC_W-1:0]   pp;
  logic [YW-1:0]      y_shift;
  logic               last_digit;
  logic               finish;

  assign y_shift    = {{2{y_q[YW-1]}}, y_q[YW-1:2]};
  assign last_digit = (cnt_q == LAST_DIGIT);

`ifdef BOOTH_SEQ_SKIP_EN
  // Remaining bits all-equal means every further digit decodes to zero.
  assign finish = last_digit | ~(|y_shift) | (&y_shift);
`else
  assign finish = last_digit;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      x_sh_q    <= '0;
      y_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      x_sh_q    <= x_sh_d;
      y_q       <= y_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_sh_d    = x_sh_q;
    y_d       = y_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    pp        = '0;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          // Multiplicand is kept at accumulator width and pre-shifted by 2 per digit,
          // which equals sign-extending then shifting by 2k.
          x_sh_d  = {{(ACC_W-WIDTH){i_multa_ns & i_multa[WIDTH-1]}}, i_multa};
          y_d     = {{2{i_multb_ns & i_multb[WIDTH-1]}}, i_multb, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        case (y_q[2:0])
          3'b001, 3'b010: pp = x_sh_q;
          3'b011:         pp = {x_sh_q[ACC_W-2:0], 1'b0};
          3'b100:         pp = -{x_sh_q[ACC_W-2:0], 1'b0};
          3'b101, 3'b110: pp = -x_sh_q;
          default:        pp = '0;
        endcase
        acc_d  = acc_q + pp;
        x_sh_d = {x_sh_q[ACC_W-3:0], 2'b00};
        y_d    = y_shift;
        cnt_d  = cnt_q + CNT_W'(1);
        if (finish) begin
          state_d   = DONE;
          product_d = acc_d[2*WIDTH-1:0];
        end
      end

      DONE: begin
        if (i_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign o_ready   = (state_q == IDLE);
  assign o_valid   = (state_q == DONE);
  assign o_product = product_q;

endmodule
